seq_detector_1011: RTL and testbench

Moore-style serial sequence detector that consumes the single-bit data stream produced by the team's D flip-flop storage stage and flags every occurrence of the bit pattern 1011. Each accepted bit advances a five-state FSM. A one-cycle `detect` pulse and a saturating match counter are produced for the downstream display/LED logic. Synchronous, single clock domain.

---
 rtl/seq_detector_1011.sv | 109 ++++++++++
 tb/tb_seq_detector_1011.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/seq_detector_1011.sv
// seq_detector_1011
//
// Moore-style serial detector for the bit pattern 1011 on a qualified
// single-bit stream. Each bit accepted with din_valid advances a five-state
// FSM. Entering S1011 produces a one-cycle registered detect pulse and bumps a
// saturating match counter.
//
// Build option: define SEQ_DET_OVERLAP_EN for overlapping detection
// (S1011 --0--> S10). Left undefined, detection is non-overlapping
// (S1011 --0--> IDLE).
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        synchronous active-low reset
//   din          serial data bit
//   din_valid    qualifies din; a bit is consumed only when this is 1
//   cnt_clr      synchronous clear of match_count (wins over an increment)
//   detect       registered one-cycle pulse: pattern just completed
//   state        current FSM state code
//   match_count  saturating detection count, COUNT_W bits
//
// state | meaning
// IDLE  | no useful prefix seen
// S1    | seen "1"
// S10   | seen "10"
// S101  | seen "101"
// S1011 | pattern complete
// 5..7  | illegal, forced back to IDLE on the next edge

module seq_detector_1011 #(
  parameter int COUNT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               din,
  input  logic               din_valid,
  input  logic               cnt_clr,
  output logic               detect,
  output logic [2:0]         state,
  output logic [COUNT_W-1:0] match_count
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    S1    = 3'd1,
    S10   = 3'd2,
    S101  = 3'd3,
    S1011 = 3'd4
  } state_t;

  localparam logic [COUNT_W-1:0] CNT_MAX = '1;

  state_t cur;
  state_t nxt;
  logic   legal;
  logic   hit;

  assign legal = (cur <= S1011);
  assign state = cur;

  always_comb begin
    nxt = cur;
    if (din_valid) begin
      unique case (cur)
        IDLE:  nxt = din ? S1    : IDLE;
        S1:    nxt = din ? S1    : S10;
        S10:   nxt = din ? S101  : IDLE;
        S101:  nxt = din ? S1011 : S10;
        S1011: begin
          if (din) begin
            nxt = S1;
          end else begin
`ifdef SEQ_DET_OVERLAP_EN
            nxt = S10;
`else
            nxt = IDLE;
`endif
          end
        end
        default: nxt = IDLE;
      endcase
    end
  end

  // Any valid bit that lands in S1011 is a match, including S101 -> S1011 only,
  // since S1011 is never re-entered from itself.
  assign hit = din_valid && legal && (nxt == S1011);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur         <= IDLE;
      detect      <= 1'b0;
      match_count <= '0;
    end else if (!legal) begin
      // Recovery edge: counter holds, no pulse.
      cur    <= IDLE;
      detect <= 1'b0;
    end else begin
      cur    <= nxt;
      detect <= hit;
      if (cnt_clr) begin
        match_count <= '0;
      end else if (hit && (match_count != CNT_MAX)) begin
        match_count <= match_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seq_detector_1011.sv
module tb_seq_detector_1011;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       din;
  logic       din_valid;
  logic       cnt_clr;
  logic       detect;
  logic [2:0] state;
  logic [1:0] match_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0] st;
    logic       det;
    logic [1:0] cnt;
    string      tag;
  } exp_t;

  exp_t exp_q[$];

  seq_detector_1011 #(.COUNT_W(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .din         (din),
    .din_valid   (din_valid),
    .cnt_clr     (cnt_clr),
    .detect      (detect),
    .state       (state),
    .match_count (match_count)
  );

  always #5 clk = ~clk;

  // Drive one edge's inputs and queue what the outputs must be after it.
  task automatic step(input logic r, input logic d, input logic v, input logic c,
                      input logic [2:0] es, input logic ed, input logic [1:0] ec,
                      input string tag);
    exp_t e;
    @(negedge clk);
    rst_n     = r;
    din       = d;
    din_valid = v;
    cnt_clr   = c;
    e.st  = es;
    e.det = ed;
    e.cnt = ec;
    e.tag = tag;
    exp_q.push_back(e);
  endtask

  task automatic pattern(input logic [1:0] c_before, input logic [1:0] c_after,
                         input logic clr_last, input string tag);
    step(1, 1, 1, 0, 3'd1, 0, c_before, tag);
    step(1, 0, 1, 0, 3'd2, 0, c_before, tag);
    step(1, 1, 1, 0, 3'd3, 0, c_before, tag);
    step(1, 1, 1, clr_last, 3'd4, 1, c_after, tag);
  endtask

  // Monitor: outputs are valid every cycle; compare one queued entry per edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (state !== e.st) begin
          errors++;
          $display("FAIL %s state: got %0d want %0d", e.tag, state, e.st);
        end
        checks++;
        if (detect !== e.det) begin
          errors++;
          $display("FAIL %s detect: got %0b want %0b", e.tag, detect, e.det);
        end
        checks++;
        if (match_count !== e.cnt) begin
          errors++;
          $display("FAIL %s match_count: got %0d want %0d", e.tag, match_count, e.cnt);
        end
      end
    end
  end

  initial begin
    rst_n = 0; din = 0; din_valid = 0; cnt_clr = 0;

    // Reset with random inputs
    for (int i = 0; i < 3; i++)
      step(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 3'd0, 0, 2'd0, "reset");

    // Basic 1011, then a hold cycle in S1011
    pattern(2'd0, 2'd1, 0, "basic");
    step(1, 0, 0, 0, 3'd4, 0, 2'd1, "basic_hold");

    // Overlap stream 1011011
    step(0, 0, 0, 0, 3'd0, 0, 2'd0, "reset2");
    pattern(2'd0, 2'd1, 0, "ovl_first");
`ifdef SEQ_DET_OVERLAP_EN
    step(1, 0, 1, 0, 3'd2, 0, 2'd1, "ovl_b5");
    step(1, 1, 1, 0, 3'd3, 0, 2'd1, "ovl_b6");
    step(1, 1, 1, 0, 3'd4, 1, 2'd2, "ovl_b7");
`else
    step(1, 0, 1, 0, 3'd0, 0, 2'd1, "novl_b5");
    step(1, 1, 1, 0, 3'd1, 0, 2'd1, "novl_b6");
    step(1, 1, 1, 0, 3'd1, 0, 2'd1, "novl_b7");
`endif

    // Valid gaps: din=1 while din_valid=0 must be ignored
    step(0, 0, 0, 0, 3'd0, 0, 2'd0, "reset3");
    step(1, 1, 1, 0, 3'd1, 0, 2'd0, "gap_b1");
    step(1, 1, 0, 0, 3'd1, 0, 2'd0, "gap_1");
    step(1, 1, 0, 0, 3'd1, 0, 2'd0, "gap_1");
    step(1, 0, 1, 0, 3'd2, 0, 2'd0, "gap_b2");
    step(1, 1, 0, 0, 3'd2, 0, 2'd0, "gap_2");
    step(1, 1, 0, 0, 3'd2, 0, 2'd0, "gap_2");
    step(1, 1, 1, 0, 3'd3, 0, 2'd0, "gap_b3");
    step(1, 1, 0, 0, 3'd3, 0, 2'd0, "gap_3");
    step(1, 1, 0, 0, 3'd3, 0, 2'd0, "gap_3");
    step(1, 1, 1, 0, 3'd4, 1, 2'd1, "gap_b4");
    step(1, 1, 0, 0, 3'd4, 0, 2'd1, "gap_after");
    step(1, 0, 0, 0, 3'd4, 0, 2'd1, "gap_after");

    // Saturation at 3 with COUNT_W=2, then clear on a matching edge
    step(0, 0, 0, 0, 3'd0, 0, 2'd0, "reset4");
    pattern(2'd0, 2'd1, 0, "sat_p1");
    pattern(2'd1, 2'd2, 0, "sat_p2");
    pattern(2'd2, 2'd3, 0, "sat_p3");
    pattern(2'd3, 2'd3, 0, "sat_p4");
    pattern(2'd3, 2'd3, 0, "sat_p5");
    pattern(2'd3, 2'd0, 1, "clr_on_match");
    pattern(2'd0, 2'd1, 0, "after_clr");
    step(1, 1, 0, 1, 3'd4, 0, 2'd0, "clr_idle");

    // Reset mid-pattern discards progress
    step(1, 1, 1, 0, 3'd1, 0, 2'd0, "mid_b1");
    step(1, 0, 1, 0, 3'd2, 0, 2'd0, "mid_b2");
    step(1, 1, 1, 0, 3'd3, 0, 2'd0, "mid_b3");
    step(0, 1, 1, 0, 3'd0, 0, 2'd0, "mid_rst");
    step(1, 1, 1, 0, 3'd1, 0, 2'd0, "mid_after");
    step(1, 0, 1, 0, 3'd2, 0, 2'd0, "mid_after");
    step(1, 1, 1, 0, 3'd3, 0, 2'd0, "mid_after");
    step(1, 1, 1, 0, 3'd4, 1, 2'd1, "mid_after");

    @(negedge clk);
    din_valid = 0;
    cnt_clr   = 0;
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
